// File: rtl/spi_burst_ram.sv
// SPI mode-0 slave in front of a single-port RAM: separate write/read pointers,
// unbounded bursts with optional auto-increment, and sticky out-of-range detection.
module spi_burst_ram #(
  parameter int MEMDEPTH  = 256,
  parameter int MEMWIDTH  = 8,
  parameter int ADDR_SIZE = 8,
  parameter int ADDR_INC  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic addr_err
);

  localparam int SR_W  = (MEMWIDTH > ADDR_SIZE) ? MEMWIDTH : ADDR_SIZE;
  localparam int CNT_W = $clog2(SR_W + 1);

  localparam logic [CNT_W-1:0]     ADDR_LAST = CNT_W'(ADDR_SIZE - 1);
  localparam logic [CNT_W-1:0]     ADDR_DONE = CNT_W'(ADDR_SIZE);
  localparam logic [CNT_W-1:0]     WORD_LAST = CNT_W'(MEMWIDTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH     = (ADDR_SIZE + 1)'(MEMDEPTH);
  localparam logic [ADDR_SIZE-1:0] PTR_LAST  = ADDR_SIZE'(MEMDEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [SR_W-1:0]      sr;
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic [MEMWIDTH-1:0]  mem [MEMDEPTH];

  // Address/word as it will be once the bit currently on MOSI is included.
  logic [ADDR_SIZE-1:0] addr_in;
  logic [MEMWIDTH-1:0]  word_in;
  logic [MEMWIDTH-1:0]  rd_word;
  logic                 addr_ok;
  logic                 mem_we;

  assign addr_in = ADDR_SIZE'({sr, MOSI});
  assign word_in = MEMWIDTH'({sr, MOSI});
  assign addr_ok = ({1'b0, addr_in} < DEPTH);
  assign rd_word = mem[rd_ptr];
  assign mem_we  = (state == WR_DATA) && !SS_n && (cnt == WORD_LAST);

  function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nx = state;
    if (state != IDLE && SS_n) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (!SS_n) state_nx = CMD;
        CMD: begin
          if (cnt != '0) begin
            case ({sr[0], MOSI})
              2'b00:   state_nx = WR_ADDR;
              2'b01:   state_nx = WR_DATA;
              2'b10:   state_nx = RD_ADDR;
              default: state_nx = RD_DATA;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO     <= 1'b0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      sr       <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      MISO <= 1'b0;
      if (SS_n) begin
        cnt <= '0;
        sr  <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            sr  <= '0;
          end
          CMD: begin
            // First command bit parks in sr[0] until the second arrives.
            if (cnt == '0) begin
              sr  <= SR_W'(MOSI);
              cnt <= CNT_W'(1);
            end else begin
              sr  <= '0;
              cnt <= '0;
            end
          end
          WR_ADDR, RD_ADDR: begin
            if (cnt < ADDR_DONE) begin
              sr  <= {sr[SR_W-2:0], MOSI};
              cnt <= cnt + 1'b1;
              if (cnt == ADDR_LAST) begin
                if (!addr_ok)              addr_err <= 1'b1;
                else if (state == WR_ADDR) wr_ptr   <= addr_in;
                else                       rd_ptr   <= addr_in;
              end
            end
          end
          WR_DATA: begin
            sr <= {sr[SR_W-2:0], MOSI};
            if (cnt == WORD_LAST) begin
              cnt <= '0;
              if (ADDR_INC != 0) wr_ptr <= ptr_next(wr_ptr);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RD_DATA: begin
            if (cnt == '0) begin
              MISO <= rd_word[MEMWIDTH-1];
              sr   <= SR_W'(rd_word);
              if (ADDR_INC != 0) rd_ptr <= ptr_next(rd_ptr);
            end else begin
              MISO <= sr[MEMWIDTH-2];
              sr   <= sr << 1;
            end
            cnt <= (cnt == WORD_LAST) ? '0 : cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the RAM array has no reset; only control state is cleared by rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= word_in;
  end

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram: three instances (defaults, MEMDEPTH=200,
// ADDR_INC=0) share clk/rst_n/MOSI and each has its own slave select.
module tb_spi_burst_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mosi;
  logic [2:0] ss_n;
  logic [2:0] miso, busy, addr_err;
  int         sel;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  spi_burst_ram u_def (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi),
    .MISO(miso[0]), .busy(busy[0]), .addr_err(addr_err[0])
  );

  spi_burst_ram #(.MEMDEPTH(200)) u_d200 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi),
    .MISO(miso[1]), .busy(busy[1]), .addr_err(addr_err[1])
  );

  spi_burst_ram #(.ADDR_INC(0)) u_noinc (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[2]), .MOSI(mosi),
    .MISO(miso[2]), .busy(busy[2]), .addr_err(addr_err[2])
  );

  typedef enum {WR_AT, RD_AT, WR_CONT, RD_CONT} kind_t;

  typedef struct {
    int                sel;
    kind_t             kind;
    logic [7:0]        addr;
    int                n;
    logic [0:2][7:0]   d;
    logic              err;
  } vec_t;

  function automatic vec_t mk(input int s, input kind_t k, input logic [7:0] a,
                              input int n, input logic [0:2][7:0] d, input logic e);
    vec_t v;
    v.sel = s; v.kind = k; v.addr = a; v.n = n; v.d = d; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // One SPI bit: inputs change on negedge, outputs are looked at 1ns after posedge.
  task automatic clock_bit(input logic ss, input logic m);
    @(negedge clk);
    ss_n      = 3'b111;
    ss_n[sel] = ss;
    mosi      = m;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start(input logic [1:0] cmd);
    clock_bit(1'b0, 1'b0);
    check("busy_rise", busy[sel], 8'd1);
    clock_bit(1'b0, cmd[1]);
    clock_bit(1'b0, cmd[0]);
  endtask

  task automatic frame_end();
    clock_bit(1'b1, 1'b0);
    check("busy_fall", busy[sel], 8'd0);
    check("miso_idle", miso[sel], 8'd0);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) clock_bit(1'b0, w[i]);
  endtask

  task automatic recv_word(output logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, 1'b0);
      w[i] = miso[sel];
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] got;
    sel = v.sel;
    if (v.kind == WR_AT || v.kind == RD_AT) begin
      frame_start((v.kind == WR_AT) ? 2'b00 : 2'b10);
      send_word(v.addr);
      frame_end();
    end
    if (v.n > 0) begin
      if (v.kind == WR_AT || v.kind == WR_CONT) begin
        frame_start(2'b01);
        for (int k = 0; k < v.n; k++) send_word(v.d[k]);
        frame_end();
      end else begin
        frame_start(2'b11);
        for (int k = 0; k < v.n; k++) begin
          recv_word(got);
          check($sformatf("v%0d_rd%0d", idx, k), got, v.d[k]);
        end
        frame_end();
      end
    end
    check($sformatf("v%0d_addr_err", idx), addr_err[sel], {7'd0, v.err});
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back(mk(0, WR_AT,   8'h10, 3, {8'hA5, 8'h3C, 8'hFF}, 1'b0));
    vecs.push_back(mk(0, WR_CONT, 8'h00, 1, {8'h77, 8'h00, 8'h00}, 1'b0));
    vecs.push_back(mk(0, RD_AT,   8'h10, 3, {8'hA5, 8'h3C, 8'hFF}, 1'b0));
    vecs.push_back(mk(0, RD_CONT, 8'h00, 1, {8'h77, 8'h00, 8'h00}, 1'b0));
    vecs.push_back(mk(0, WR_AT,   8'hFF, 2, {8'h11, 8'h22, 8'h00}, 1'b0));
    vecs.push_back(mk(0, WR_CONT, 8'h00, 1, {8'h33, 8'h00, 8'h00}, 1'b0));
    vecs.push_back(mk(0, RD_AT,   8'hFF, 3, {8'h11, 8'h22, 8'h33}, 1'b0));
    vecs.push_back(mk(1, WR_AT,   8'hC7, 1, {8'h9E, 8'h00, 8'h00}, 1'b0));
    vecs.push_back(mk(1, WR_AT,   8'hC8, 0, {8'h00, 8'h00, 8'h00}, 1'b1));
    vecs.push_back(mk(1, WR_CONT, 8'h00, 1, {8'hC1, 8'h00, 8'h00}, 1'b1));
    vecs.push_back(mk(1, WR_AT,   8'h05, 1, {8'h5A, 8'h00, 8'h00}, 1'b1));
    vecs.push_back(mk(1, RD_AT,   8'hC7, 2, {8'h9E, 8'hC1, 8'h00}, 1'b1));
    vecs.push_back(mk(1, RD_AT,   8'h05, 1, {8'h5A, 8'h00, 8'h00}, 1'b1));
    vecs.push_back(mk(2, WR_AT,   8'h21, 1, {8'hAA, 8'h00, 8'h00}, 1'b0));
    vecs.push_back(mk(2, WR_AT,   8'h20, 2, {8'h01, 8'h02, 8'h00}, 1'b0));
    vecs.push_back(mk(2, RD_AT,   8'h20, 2, {8'h02, 8'h02, 8'h00}, 1'b0));
    vecs.push_back(mk(2, RD_AT,   8'h21, 1, {8'hAA, 8'h00, 8'h00}, 1'b0));

    rst_n = 1'b0;
    ss_n  = 3'b111;
    mosi  = 1'b0;
    sel   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_miso%0d", i), miso[i], 8'd0);
      check($sformatf("rst_busy%0d", i), busy[i], 8'd0);
      check($sformatf("rst_err%0d", i), addr_err[i], 8'd0);
    end

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Abort a write burst after five data bits: nothing written, pointer kept.
    run_vec(100, mk(0, WR_AT, 8'h30, 2, {8'hC3, 8'h4B, 8'h00}, 1'b0));
    run_vec(101, mk(0, WR_AT, 8'h31, 0, {8'h00, 8'h00, 8'h00}, 1'b0));
    sel = 0;
    frame_start(2'b01);
    repeat (5) clock_bit(1'b0, 1'b1);
    clock_bit(1'b1, 1'b0);
    check("abort_busy", busy[0], 8'd0);
    run_vec(102, mk(0, RD_AT,   8'h30, 2, {8'hC3, 8'h4B, 8'h00}, 1'b0));
    run_vec(103, mk(0, WR_CONT, 8'h00, 1, {8'h5E, 8'h00, 8'h00}, 1'b0));
    run_vec(104, mk(0, RD_AT,   8'h30, 2, {8'hC3, 8'h5E, 8'h00}, 1'b0));

    // Reset in the middle of a read burst.
    run_vec(105, mk(0, RD_AT, 8'h10, 0, {8'h00, 8'h00, 8'h00}, 1'b0));
    sel = 0;
    frame_start(2'b11);
    repeat (3) clock_bit(1'b0, 1'b0);
    check("pre_rst_miso", miso[0], 8'd1);
    #2;
    rst_n = 1'b0;
    ss_n  = 3'b111;
    #1;
    check("mid_rst_miso", miso[0], 8'd0);
    check("mid_rst_busy", busy[0], 8'd0);
    check("mid_rst_err1", addr_err[1], 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clock_bit(1'b1, 1'b0);
    run_vec(106, mk(0, RD_CONT, 8'h00, 2, {8'h22, 8'h33, 8'h00}, 1'b0));
    run_vec(107, mk(0, WR_CONT, 8'h00, 1, {8'h66, 8'h00, 8'h00}, 1'b0));
    run_vec(108, mk(0, RD_AT,   8'h00, 2, {8'h66, 8'h33, 8'h00}, 1'b0));
    run_vec(109, mk(0, RD_AT,   8'h10, 3, {8'hA5, 8'h3C, 8'hFF}, 1'b0));
    run_vec(110, mk(2, RD_AT,   8'h20, 1, {8'h02, 8'h00, 8'h00}, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
- SPI slave (mode 0, sampling on `clk` posedge, `SS_n` framed) with an embedded single-port RAM. Next generation of the team's SPI slave + single-port RAM pair.
- Adds separate write and read pointers, burst transfers with optional auto-increment, and non-power-of-two depth with out-of-range address detection.
- Sits between an external SPI master and on-chip register/buffer storage.

Parameters:
- MEMDEPTH, 256, number of RAM words; 2 <= MEMDEPTH <= 2**ADDR_SIZE.
- MEMWIDTH, 8, bits per RAM word; also the SPI data word length.
- ADDR_SIZE, 8, address field length in bits.
- ADDR_INC, 1, 1 = pointer increments after each burst word; 0 = pointer holds, so repeated access hits the same word.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  active-low slave select, frames one command.
- MOSI  input  1  serial in, MSB first, sampled on posedge.
- MISO  output  1  serial out, MSB first, registered, changes on posedge.
- busy  output  1  high while the FSM is not IDLE.
- addr_err  output  1  sticky flag: an out-of-range address was received.

Behaviour:
- Reset, asynchronous: MISO=0, busy=0, addr_err=0, wr_ptr=0, rd_ptr=0, FSM=IDLE, shift registers cleared. RAM contents are not reset.
- Edge numbering: E0 = first posedge with SS_n=0 while IDLE; FSM goes IDLE->CMD and MOSI is ignored.
- Command bits: E1 and E2 sample c1 and c0. At E2 the FSM enters:
  - 00 -> WR_ADDR
  - 01 -> WR_DATA
  - 10 -> RD_ADDR
  - 11 -> RD_DATA
- WR_ADDR / RD_ADDR:
  - E3..E(2+ADDR_SIZE) shift in the address, MSB first.
  - At E(2+ADDR_SIZE), if addr < MEMDEPTH, wr_ptr / rd_ptr is loaded.
  - Otherwise the pointer is unchanged and addr_err is set to 1. addr_err stays set until reset.
  - Further MOSI bits in the frame are ignored.
- WR_DATA (burst):
  - Word k occupies E(3+k*W)..E(2+(k+1)*W), where W = MEMWIDTH.
  - At the last-bit edge, mem[wr_ptr] is written with the assembled word.
  - If ADDR_INC=1, wr_ptr then increments, wrapping MEMDEPTH-1 -> 0.
  - Bursts are unbounded.
- RD_DATA (burst):
  - MOSI is ignored.
  - At E3, the shift register loads mem[rd_ptr]; MISO = bit W-1 from E3. rd_ptr increments (wrapping) if ADDR_INC=1.
  - Each following posedge shifts out the next bit.
  - At E(3+k*W) the next word is loaded with no gap bit.
  - MISO=0 in every other state.
- SS_n rising:
  - Sampled at a posedge; FSM returns to IDLE at that edge and MISO=0.
  - A partial word or address is discarded; no RAM write and no pointer change.
  - A pointer update from a completed word or address is kept.
- SS_n must be high for at least 1 posedge between frames. A frame starting the edge after return to IDLE is legal.
- busy = (FSM != IDLE), registered, so it rises at E0.
- Single port: at most one RAM access per cycle. Reads and writes never coincide because frames are exclusive.
- Reset mid-frame: immediate abort to reset values. A RAM write is never half-done.
- RTL scope: FSM (IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), bit counter of width clog2(max(W, ADDR_SIZE)+1), two pointers, RAM array.

Test Plan:
- Write address then burst write, defaults:
  - Stimulus: frame 00+0x10; then frame 01 followed by words 0xA5, 0x3C, 0xFF.
  - Required: mem[0x10..0x12] = A5, 3C, FF; wr_ptr = 0x13; busy high during each frame only.
- Burst read:
  - Stimulus: frame 10+0x10; then frame 11 held for 24 bits after the command bits.
  - Required: MISO outputs A5, 3C, FF MSB first, starting at E3 with no gaps; rd_ptr = 0x13.
- Wrap-around:
  - Stimulus: write address 0xFF; burst-write 0x11, 0x22.
  - Required: mem[0xFF]=0x11, mem[0x00]=0x22, wr_ptr=0x01.
- Out-of-range address, MEMDEPTH=200:
  - Stimulus: frame 00+0xC8.
  - Required: addr_err=1, wr_ptr unchanged.
  - Stimulus: frame 00+0x05.
  - Required: wr_ptr=0x05 and addr_err stays 1.
- Abort:
  - Stimulus: raise SS_n after 5 data bits of WR_DATA.
  - Required: no RAM change, wr_ptr unchanged, busy=0 at the next edge.
  - Stimulus: assert rst_n=0 mid-RD_DATA.
  - Required: MISO=0, pointers=0, RAM intact.
- ADDR_INC=0:
  - Stimulus: burst-write 0x01, 0x02 at address 0x20.
  - Required: mem[0x20]=0x02, mem[0x21] unchanged; a 16-bit read returns 0x02, 0x02.
